// File: rtl/qupls_preg_freelist_if.sv
// Renamer <-> physical register free list bundle: allocation ports, commit frees,
// branch-miss restore and the published free vector.
interface qupls_preg_freelist_if #(
    parameter int PREGS = 192
);
    localparam int RBIT = $clog2(PREGS);
    localparam int CBIT = $clog2(PREGS + 1);

    logic [3:0]           alloc_i;
    logic [3:0][RBIT-1:0] wrr_o;
    logic [3:0]           wrr_v_o;
    logic                 stall_o;
    logic [3:0]           free_v_i;
    logic [3:0][RBIT-1:0] free_i;
    logic                 restore_i;
    logic [PREGS-1:0]     free_bitlist_i;
    logic [PREGS-1:0]     avail_o;
    logic [CBIT-1:0]      free_cnt_o;
    logic                 err_o;

    modport master (
        output alloc_i, free_v_i, free_i, restore_i, free_bitlist_i,
        input  wrr_o, wrr_v_o, stall_o, avail_o, free_cnt_o, err_o
    );

    modport slave (
        input  alloc_i, free_v_i, free_i, restore_i, free_bitlist_i,
        output wrr_o, wrr_v_o, stall_o, avail_o, free_cnt_o, err_o
    );
endinterface

// File: rtl/qupls_preg_freelist.sv
// Q+ physical register free list: four interleaved banks, one allocation port per bank.
// Optional double-free / invalid-allocate checking under QUPLS_FREELIST_ERRCHK_EN.
module qupls_preg_freelist #(
    parameter int PREGS = 192,
    parameter int AREGS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    qupls_preg_freelist_if.slave  fl
);
    localparam int RBIT   = $clog2(PREGS);
    localparam int CBIT   = $clog2(PREGS + 1);
    localparam int BDEPTH = PREGS / 4;

    function automatic logic [PREGS-1:0] reset_avail();
        logic [PREGS-1:0] v;
        v = {PREGS{1'b0}};
        for (int p = AREGS; p < PREGS; p++) begin
            v[p] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [CBIT-1:0] popcount(input logic [PREGS-1:0] v);
        logic [CBIT-1:0] c;
        c = {CBIT{1'b0}};
        for (int p = 0; p < PREGS; p++) begin
            c = c + CBIT'(v[p]);
        end
        return c;
    endfunction

    localparam logic [PREGS-1:0] AVAIL_RST = reset_avail();

    logic [PREGS-1:0]     avail_q, avail_d;
    logic [3:0][RBIT-1:0] wrr_q, wrr_d;
    logic [3:0]           wrr_v_q, wrr_v_d;
    logic [CBIT-1:0]      free_cnt_q, free_cnt_d;
    logic                 err_q, err_d;

    logic [3:0]           alloc_ok_s;
    logic [PREGS-1:0]     alloc_mask_s;
    logic [PREGS-1:0]     free_mask_s;
    logic [PREGS-1:0]     restore_mask_s;

    // Restore suppresses every allocation port, so it can never stall.
    assign alloc_ok_s = fl.alloc_i & wrr_v_q & {4{~fl.restore_i}};
    assign fl.stall_o = (|(fl.alloc_i & ~wrr_v_q)) & ~fl.restore_i;

    // Next-state free vector: allocations cleared first, then frees and restore OR'd in.
    always_comb begin
        alloc_mask_s   = {PREGS{1'b0}};
        free_mask_s    = {PREGS{1'b0}};
        restore_mask_s = fl.restore_i ? fl.free_bitlist_i : {PREGS{1'b0}};
        restore_mask_s[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (alloc_ok_s[k] && (int'(wrr_q[k]) < PREGS)) begin
                alloc_mask_s[wrr_q[k]] = 1'b1;
            end else begin
                alloc_mask_s = alloc_mask_s;
            end
        end
        // Preg 0 is hard-wired in use; frees of it are silently dropped.
        for (int s = 0; s < 4; s++) begin
            if (fl.free_v_i[s] && (fl.free_i[s] != RBIT'(0)) && (int'(fl.free_i[s]) < PREGS)) begin
                free_mask_s[fl.free_i[s]] = 1'b1;
            end else begin
                free_mask_s = free_mask_s;
            end
        end
        avail_d = (avail_q & ~alloc_mask_s) | free_mask_s | restore_mask_s;
    end

    // Per-bank candidate: lowest free preg of the bank; an empty bank keeps its old number.
    always_comb begin
        wrr_d   = wrr_q;
        wrr_v_d = 4'h0;
        for (int k = 0; k < 4; k++) begin
            for (int j = BDEPTH - 1; j >= 0; j--) begin
                wrr_d[k]   = avail_d[4*j + k] ? RBIT'(4*j + k) : wrr_d[k];
                wrr_v_d[k] = avail_d[4*j + k] | wrr_v_d[k];
            end
        end
    end

    // Free count and sticky error flag.
    always_comb begin
        free_cnt_d = popcount(avail_d);
`ifdef QUPLS_FREELIST_ERRCHK_EN
        err_d = err_q
              | (|(free_mask_s & avail_q))
              | (|(restore_mask_s & avail_q))
              | (|(free_mask_s & alloc_mask_s));
`else
        err_d = 1'b0;
`endif
    end

    // State registers; reset maps the first AREGS pregs to the architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avail_q <= AVAIL_RST;
            for (int k = 0; k < 4; k++) begin
                wrr_q[k] <= RBIT'(AREGS + k);
            end
            wrr_v_q    <= 4'hF;
            free_cnt_q <= CBIT'(PREGS - AREGS);
            err_q      <= 1'b0;
        end else begin
            avail_q    <= avail_d;
            wrr_q      <= wrr_d;
            wrr_v_q    <= wrr_v_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign fl.avail_o    = avail_q;
    assign fl.wrr_o      = wrr_q;
    assign fl.wrr_v_o    = wrr_v_q;
    assign fl.free_cnt_o = free_cnt_q;
    assign fl.err_o      = err_q;

endmodule

// File: tb/tb_qupls_preg_freelist.sv
// Directed + light random bench for qupls_preg_freelist with a reference model
// feeding an expected-result queue.
module tb_qupls_preg_freelist;
    localparam int PREGS = 192;
    localparam int AREGS = 64;
    localparam int RBIT  = 8;
    localparam int CBIT  = 8;

    typedef struct {
        logic [3:0][RBIT-1:0] wrr;
        logic [3:0]           wv;
        logic [CBIT-1:0]      cnt;
        logic                 err;
        logic [PREGS-1:0]     avail;
    } exp_t;

    exp_t sb_q[$];

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [PREGS-1:0]     avail_m;
    logic [3:0][RBIT-1:0] wrr_m;
    logic [3:0]           wv_m;
    logic                 err_m;
    logic [CBIT-1:0]      cnt_prev;
    logic [PREGS-1:0]     bl_v;
    logic [3:0][RBIT-1:0] fr_v;
    logic                 err_exp;

    always #5 clk = ~clk;

    qupls_preg_freelist_if #(.PREGS(PREGS)) fl ();

    qupls_preg_freelist #(.PREGS(PREGS), .AREGS(AREGS)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    task automatic chk(input string tag, input logic [PREGS-1:0] obs, input logic [PREGS-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CBIT-1:0] cnt_of(input logic [PREGS-1:0] v);
        logic [CBIT-1:0] c;
        c = 8'd0;
        for (int p = 0; p < PREGS; p++) if (v[p]) c = c + 8'd1;
        return c;
    endfunction

    task automatic model_reset();
        avail_m = '0;
        for (int p = AREGS; p < PREGS; p++) avail_m[p] = 1'b1;
        for (int k = 0; k < 4; k++) wrr_m[k] = RBIT'(AREGS + k);
        wv_m  = 4'hF;
        err_m = 1'b0;
    endtask

    task automatic model_cand();
        for (int k = 0; k < 4; k++) begin
            wv_m[k] = 1'b0;
            for (int p = k; p < PREGS; p += 4) begin
                if (avail_m[p] && !wv_m[k]) begin
                    wrr_m[k] = RBIT'(p);
                    wv_m[k]  = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_avail"}, fl.avail_o, avail_m);
        chk({tag, "_wrr"}, fl.wrr_o, wrr_m);
        chk({tag, "_wrr_v"}, fl.wrr_v_o, wv_m);
        chk({tag, "_cnt"}, fl.free_cnt_o, cnt_of(avail_m));
        chk({tag, "_err"}, fl.err_o, err_m);
    endtask

    task automatic step(input logic [3:0] alloc, input logic [3:0] fv,
                        input logic [3:0][RBIT-1:0] fr, input logic rs,
                        input logic [PREGS-1:0] bl);
        logic [PREGS-1:0] am, fm, rm;
        exp_t e;
        fl.alloc_i        = alloc;
        fl.free_v_i       = fv;
        fl.free_i         = fr;
        fl.restore_i      = rs;
        fl.free_bitlist_i = bl;
        #1;
        chk("stall", fl.stall_o, (|(alloc & ~wv_m)) & ~rs);
        am = '0; fm = '0;
        rm = rs ? bl : '0;
        rm[0] = 1'b0;
        for (int k = 0; k < 4; k++) if (alloc[k] && wv_m[k] && !rs) am[wrr_m[k]] = 1'b1;
        for (int s = 0; s < 4; s++) if (fv[s] && fr[s] != 8'd0 && int'(fr[s]) < PREGS) fm[fr[s]] = 1'b1;
`ifdef QUPLS_FREELIST_ERRCHK_EN
        if ((|(fm & avail_m)) || (|(rm & avail_m)) || (|(fm & am))) err_m = 1'b1;
`endif
        avail_m = (avail_m & ~am) | fm | rm;
        model_cand();
        e.wrr = wrr_m; e.wv = wv_m; e.cnt = cnt_of(avail_m); e.err = err_m; e.avail = avail_m;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("avail", fl.avail_o, e.avail);
        chk("wrr", fl.wrr_o, e.wrr);
        chk("wrr_v", fl.wrr_v_o, e.wv);
        chk("free_cnt", fl.free_cnt_o, e.cnt);
        chk("err", fl.err_o, e.err);
    endtask

    task automatic idle();
        step(4'h0, 4'h0, '0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b0;
        fl.alloc_i = 4'h0; fl.free_v_i = 4'h0; fl.free_i = '0;
        fl.restore_i = 1'b0; fl.free_bitlist_i = '0;
        model_reset();
        #12;
        chk_state("reset");
        chk("reset_wrr_const", fl.wrr_o, {8'd67, 8'd66, 8'd65, 8'd64});
        chk("reset_wrr_v_const", fl.wrr_v_o, 4'hF);
        chk("reset_cnt_const", fl.free_cnt_o, 8'd128);
        chk("reset_low_zero", fl.avail_o[63:0], 64'd0);
        @(negedge clk);
        rst = 1'b1;

        step(4'hF, 4'h0, '0, 1'b0, '0);
        chk("alloc4_wrr_const", fl.wrr_o, {8'd71, 8'd70, 8'd69, 8'd68});
        chk("alloc4_cnt_const", fl.free_cnt_o, 8'd124);
        chk("alloc4_bits_clear", fl.avail_o[67:64], 4'h0);

        for (int i = 0; i < 32; i++) step(4'h2, 4'h0, '0, 1'b0, '0);
        chk("drain_wrr_v1", fl.wrr_v_o[1], 1'b0);
        cnt_prev = fl.free_cnt_o;
        step(4'h2, 4'h0, '0, 1'b0, '0);
        chk("drain_stall_const", fl.stall_o, 1'b1);
        chk("drain_cnt_same", fl.free_cnt_o, cnt_prev);

        step(4'h0, 4'h1, {8'd0, 8'd0, 8'd0, 8'd5}, 1'b0, '0);
        chk("refill_wrr_v1", fl.wrr_v_o[1], 1'b1);
        chk("refill_wrr1", fl.wrr_o[1], 8'd5);

        cnt_prev = fl.free_cnt_o;
        step(4'h0, 4'hF, {8'd12, 8'd8, 8'd4, 8'd0}, 1'b0, '0);
        chk("free0_dropped", fl.avail_o[0], 1'b0);
        chk("free_bits_4_8_12", {fl.avail_o[12], fl.avail_o[8], fl.avail_o[4]}, 3'b111);
        chk("free_wrr0", fl.wrr_o[0], 8'd4);
        chk("free_cnt_plus3", fl.free_cnt_o, cnt_prev + 8'd3);

        cnt_prev = fl.free_cnt_o;
        bl_v = '0; bl_v[64] = 1'b1; bl_v[65] = 1'b1;
        step(4'hF, 4'h0, '0, 1'b1, bl_v);
        chk("restore_bits", {fl.avail_o[65], fl.avail_o[64]}, 2'b11);
        chk("restore_cnt_plus2", fl.free_cnt_o, cnt_prev + 8'd2);
        chk("restore_no_alloc", fl.avail_o[4], 1'b1);

        step(4'h2, 4'hF, {8'd81, 8'd77, 8'd73, 8'd69}, 1'b0, '0);
        chk("samebank_alloc5", fl.avail_o[5], 1'b0);
        chk("samebank_frees", {fl.avail_o[81], fl.avail_o[77], fl.avail_o[73], fl.avail_o[69]}, 4'hF);
        chk("samebank_wrr1", fl.wrr_o[1], 8'd65);

`ifdef QUPLS_FREELIST_ERRCHK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        step(4'h0, 4'h1, {8'd0, 8'd0, 8'd0, 8'd100}, 1'b0, '0);
        chk("dblfree_err", fl.err_o, err_exp);
        idle();
        idle();
        chk("dblfree_err_hold", fl.err_o, err_exp);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("err_cleared_by_reset", fl.err_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 60; i++) begin
            for (int s = 0; s < 4; s++) fr_v[s] = RBIT'($urandom_range(0, PREGS - 1));
            bl_v = '0;
            bl_v[$urandom_range(0, PREGS - 1)] = 1'b1;
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), fr_v,
                 ($urandom_range(0, 7) == 0), bl_v);
        end

        fl.alloc_i = 4'hF; fl.free_v_i = 4'hF; fl.restore_i = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_state("midop_reset");
        fl.alloc_i = 4'h0; fl.free_v_i = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qupls_preg_freelist.md
# qupls_preg_freelist

Physical register free list for the Q+ renamer. It tracks which of PREGS physical registers are free and hands out up to four new destination registers per cycle to the register alias table. It reclaims registers released at commit, and bulk-reclaims the bit vector of discarded registers on a branch-miss restore. It publishes the registered free vector that the alias table snapshots into each new checkpoint.

## Interface
- PREGS, 192: physical register count; a multiple of 4.
- AREGS, 64: architectural registers mapped at reset; a multiple of 4, less than PREGS.
- RBIT, $clog2(PREGS): physical register number width (derived, not overridable).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_i  in  4  bit k: the consumer takes candidate wrr_o[k] this cycle.
- wrr_o  out  4 x RBIT  per-port candidate physical register (registered).
- wrr_v_o  out  4  candidate k is valid (its bank is non-empty).
- stall_o  out  1  combinational; equals |(alloc_i & ~wrr_v_o) & ~restore_i.
- free_v_i  in  4  commit-side free valid, one per commit slot.
- free_i  in  4 x RBIT  register to free, per slot.
- restore_i  in  1  branch-miss restore.
- free_bitlist_i  in  PREGS  registers discarded by the restore.
- avail_o  out  PREGS  registered free vector; bit p set means preg p is free.
- free_cnt_o  out  $clog2(PREGS+1)  registered popcount of avail_o.
- err_o  out  1  sticky double-free / invalid-allocate flag.

## Operation
- Free vector is split into 4 interleaved banks. Bank k holds the pregs p with p%4==k. Port k allocates only from bank k.
- Candidate for bank k is the lowest-numbered free preg in bank k of the next-state vector. It is registered into wrr_o[k]. wrr_v_o[k]=0 when the bank is empty; wrr_o[k] then holds its last value.
- Allocation: alloc_i[k] & wrr_v_o[k] clears bit wrr_o[k]. An alloc_i[k] with !wrr_v_o[k] causes no state change and raises stall_o.
- Commit free: each free_v_i[s] sets bit free_i[s].
- Restore: avail_next = avail | free_bitlist_i | commit frees. All alloc_i are ignored in the restore cycle, and stall_o=0 in that cycle.
- Next-state order: avail_next = (avail & ~alloc_mask) | free_mask | (restore_i ? free_bitlist_i : 0).
- A register both allocated and freed in the same cycle ends up free. This is only legal as a double-free; see Configuration.
- Preg 0 is never freed. A free of preg 0 is dropped.
- Four frees targeting the same bank, alongside an allocation from that bank, are all applied in one cycle.

## Timing
- Reset (rst=0, asynchronous):
  - avail_o = ones in bits AREGS..PREGS-1, zeros elsewhere.
  - wrr_o[k] = AREGS+k.
  - wrr_v_o = 4'hF.
  - free_cnt_o = PREGS-AREGS.
  - err_o = 0.
- Reset asserted mid-operation discards all pending allocations and frees immediately.
- Allocate-to-new-candidate latency: 1 cycle. After alloc_i[k] at edge N, wrr_o[k] shows the next free bank-k preg after edge N.
- Free-to-available latency: 1 cycle. A preg freed at edge N is visible in avail_o, and eligible as a candidate, after edge N.
- avail_o and free_cnt_o update on the same edge as the vector state; no extra stage.
- stall_o has no registered component. It must settle within the cycle alloc_i is presented.

## Configuration
- QUPLS_FREELIST_ERRCHK_EN defined:
  - err_o is set (and stays set until reset) when a commit free targets a preg already free in avail_o, or a restore bit overlaps an already-free preg, or a free targets a preg being allocated that cycle.
  - The offending free is still applied, so the bit stays set.
- QUPLS_FREELIST_ERRCHK_EN undefined: err_o is tied 0 and the checking logic is not compiled.

## Test plan
- Reset with PREGS=192, AREGS=64 -> wrr_o={67,66,65,64}, wrr_v_o=4'hF, free_cnt_o=128, avail_o[63:0]=0.
- alloc_i=4'hF for one cycle after reset -> next cycle wrr_o={71,70,69,68}, free_cnt_o=124, avail_o bits 64-67 clear.
- Drain bank 1 with alloc_i=4'h2 for 32 cycles -> wrr_v_o[1]=0. Then assert alloc_i=4'h2 -> stall_o=1 and free_cnt_o unchanged. Free preg 5 -> next cycle wrr_v_o[1]=1, wrr_o[1]=5.
- Issue free_v_i=4'hF with free_i={12,8,4,0} -> preg 0 dropped, bits 4, 8 and 12 set, wrr_o[0]=4 next cycle, free_cnt_o +3.
- restore_i=1 with free_bitlist_i bits {64,65} set (previously allocated) and alloc_i=4'hF -> allocations ignored, stall_o=0, both bits set next cycle, free_cnt_o +2.
- With QUPLS_FREELIST_ERRCHK_EN: free preg 100 while it is free -> err_o=1 next cycle and it holds until rst=0. Without the macro -> err_o stays 0.
